// File: rtl/muldiv_seq_unit.sv
// Sequential RV32M execution unit: 2-cycle multiply, 32-step restoring divide,
// start/busy/result_valid handshake with pipeline flush.
module muldiv_seq_unit #(
  parameter int WIDTH     = 32,
  parameter int ITER_BITS = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [4:0]       i_alu_control,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               r_state;
  logic                 r_busy;
  logic                 r_result_valid;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_divisor;
  logic [ITER_BITS-1:0] r_count;
  logic [1:0]           r_op;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic                 w_accept;
  logic                 w_is_div;
  logic                 w_div_signed;
  logic                 w_div_rem;
  logic                 w_div_zero;
  logic                 w_overflow;
  logic [WIDTH-1:0]     w_abs1;
  logic [WIDTH-1:0]     w_abs2;
  logic [WIDTH-1:0]     w_special;
  logic                 w_mul_a_signed;
  logic                 w_mul_b_signed;
  logic [2*WIDTH-1:0]   w_mul_a;
  logic [2*WIDTH-1:0]   w_mul_b;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH-1:0]     w_mul_result;
  logic [WIDTH:0]       w_shifted;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_quo_final;
  logic [WIDTH-1:0]     w_rem_final;
  logic [WIDTH-1:0]     w_div_result;

  // Accept-time decode: op class, operand magnitudes and the two shortcut divide cases.
  always_comb begin
    w_accept     = i_start && !i_flush && (r_state == S_IDLE) && (i_alu_control[4:3] == 2'b01);
    w_is_div     = i_alu_control[2];
    w_div_signed = !i_alu_control[0];
    w_div_rem    = i_alu_control[1];
    w_abs1       = (w_div_signed && i_data1[WIDTH-1]) ? -i_data1 : i_data1;
    w_abs2       = (w_div_signed && i_data2[WIDTH-1]) ? -i_data2 : i_data2;
    w_div_zero   = (i_data2 == '0);
    w_overflow   = w_div_signed && (i_data1 == MIN_NEG) && (i_data2 == '1);
    w_special    = '0;
    if (w_div_zero) begin
      w_special = w_div_rem ? i_data1 : '1;
    end else if (w_overflow) begin
      w_special = w_div_rem ? '0 : MIN_NEG;
    end
  end

  // Sign-extending both operands to 2*WIDTH makes one unsigned multiply cover every signedness mix.
  always_comb begin
    w_mul_a_signed = (r_op == 2'b01) || (r_op == 2'b11);
    w_mul_b_signed = (r_op == 2'b01);
    w_mul_a        = {{WIDTH{w_mul_a_signed & r_quo[WIDTH-1]}}, r_quo};
    w_mul_b        = {{WIDTH{w_mul_b_signed & r_divisor[WIDTH-1]}}, r_divisor};
    w_product      = w_mul_a * w_mul_b;
    w_mul_result   = (r_op == 2'b00) ? w_product[WIDTH-1:0] : w_product[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    w_shifted    = {r_rem, r_quo[WIDTH-1]};
    w_trial      = w_shifted - {1'b0, r_divisor};
    w_quo_final  = r_neg_q ? -r_quo : r_quo;
    w_rem_final  = r_neg_r ? -r_rem : r_rem;
    w_div_result = r_op[1] ? w_rem_final : w_quo_final;
  end

  // Results are registered on the edge into DONE so result_valid lines up with the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_quo          <= '0;
      r_rem          <= '0;
      r_divisor      <= '0;
      r_count        <= '0;
      r_op           <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_result_valid <= 1'b0;
          if (w_accept) begin
            r_op    <= i_alu_control[1:0];
            r_count <= '0;
            r_busy  <= 1'b1;
            if (!w_is_div) begin
              r_quo     <= i_data1;
              r_divisor <= i_data2;
              r_rem     <= '0;
              r_state   <= S_MUL;
            end else if (w_div_zero || w_overflow) begin
              r_result       <= w_special;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_quo     <= w_abs1;
              r_divisor <= w_abs2;
              r_rem     <= '0;
              r_neg_q   <= w_div_signed && (i_data1[WIDTH-1] ^ i_data2[WIDTH-1]);
              r_neg_r   <= w_div_signed && i_data1[WIDTH-1];
              r_state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else begin
            r_result       <= w_mul_result;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DIV: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else if (r_count == ITER_BITS'(WIDTH)) begin
            r_result       <= w_div_result;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_rem   <= w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_quo   <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
            r_count <= r_count + ITER_BITS'(1);
          end
        end
        S_DONE: begin
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_result       = r_result;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: cycle-by-cycle comparison against a
// latency/result model plus literal expectations from hand-computed vectors.
module tb_muldiv_seq_unit;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHU  = 5'b01010;
  localparam logic [4:0] OP_MULHSU = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  aluControl = 5'b0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        resultValid;
  logic [31:0] result;

  int nVectors = 0;
  int nMis = 0;

  muldiv_seq_unit #(.WIDTH(32), .ITER_BITS(6)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_alu_control  (aluControl),
    .i_data1        (data1),
    .i_data2        (data2),
    .i_flush        (flush),
    .o_busy         (busy),
    .o_result_valid (resultValid),
    .o_result       (result)
  );

  always #5 clk = ~clk;

  // Architectural result of an RV32M op, straight from the ISA rules.
  function automatic logic [31:0] refResult(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint    sp;
    logic [63:0] up;
    int        ia;
    int        ib;
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      OP_MUL:    begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      OP_MULH:   begin sp = longint'(ia) * longint'(ib); up = sp; return up[63:32]; end
      OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      OP_MULHSU: begin sp = longint'(ia) * longint'({32'b0, b}); up = sp; return up[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int refLatency(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Model: an accepted op is "in flight" for refLatency cycles; result appears in its last cycle.
  bit          modelReady = 1'b0;
  bit          mActive = 1'b0;
  int          mAge = 0;
  int          mLat = 0;
  logic [31:0] mPending = '0;
  logic [31:0] mExpResult = '0;

  always @(posedge clk) begin
    if (reset) begin
      mActive    <= 1'b0;
      mAge       <= 0;
      mExpResult <= '0;
      modelReady <= 1'b1;
    end else if (mActive) begin
      if (mAge == mLat || flush) begin
        mActive <= 1'b0;
      end else begin
        mAge <= mAge + 1;
        if (mAge + 1 == mLat) mExpResult <= mPending;
      end
    end else if (start && !flush && aluControl[4:3] == 2'b01) begin
      mActive  <= 1'b1;
      mAge     <= 1;
      mLat     <= refLatency(aluControl, data1, data2);
      mPending <= refResult(aluControl, data1, data2);
      if (refLatency(aluControl, data1, data2) == 1)
        mExpResult <= refResult(aluControl, data1, data2);
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("result_valid", 32'(resultValid), 32'(mActive && (mAge == mLat)));
      checkOutput("result", result, mExpResult);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle; operands are scrambled afterwards so latching is exercised.
  task automatic applyStimulus(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    start      = 1'b1;
    aluControl = op;
    data1      = a;
    data2      = b;
    step();
    start      = 1'b0;
    aluControl = 5'b0;
    data1      = 32'hDEAD_BEEF;
    data2      = 32'h1234_5678;
  endtask

  task automatic waitResult(string name, int cycStart, logic [31:0] expRes, int expLat);
    int cyc;
    cyc = cycStart;
    while (!resultValid && cyc < 80) begin
      step();
      cyc++;
    end
    checkOutput({name, " value"}, result, expRes);
    checkOutput({name, " latency"}, 32'(cyc), 32'(expLat));
    step();
  endtask

  task automatic runOp(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] expRes, int expLat);
    applyStimulus(op, a, b);
    waitResult(name, 1, expRes, expLat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset valid", 32'(resultValid), 32'h0);
    checkOutput("reset result", result, 32'h0);

    runOp("MUL 7x6", OP_MUL, 32'd7, 32'd6, 32'd42, 2);
    runOp("MULH min*min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    runOp("MULHU -1*-1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    runOp("MULHSU -1*-1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // Flush during DONE must not suppress the committed result.
    applyStimulus(OP_MUL, 32'd5, 32'd5);
    step();
    flush = 1'b1;
    checkOutput("flush-in-done valid", 32'(resultValid), 32'h1);
    checkOutput("flush-in-done result", result, 32'd25);
    step();
    flush = 1'b0;

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("reset-mid busy", 32'(busy), 32'h0);
    checkOutput("reset-mid valid", 32'(resultValid), 32'h0);
    checkOutput("reset-mid result", result, 32'h0);
    runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    runOp("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

    runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    runOp("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);

    runOp("DIV 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REM 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    runOp("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REMU 5/0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    runOp("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    runOp("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    runOp("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    runOp("DIVU big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
    runOp("REMU big", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    runOp("MUL -1*2", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2);
    runOp("MULH -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2);
    runOp("MULHSU min*2", OP_MULHSU, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 2);

    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (11) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy), 32'h0);
    checkOutput("flush valid", 32'(resultValid), 32'h0);
    checkOutput("flush result held", result, 32'hFFFF_FFFF);
    runOp("REMU 1000/3", OP_REMU, 32'd1000, 32'd3, 32'd1, 34);

    // Flush together with start in IDLE wins.
    flush = 1'b1;
    applyStimulus(OP_DIVU, 32'd50, 32'd5);
    flush = 1'b0;
    checkOutput("flush+start busy", 32'(busy), 32'h0);
    step();

    applyStimulus(OP_DIVU, 32'd9, 32'd2);
    repeat (4) step();
    applyStimulus(OP_MUL, 32'd3, 32'd4);
    waitResult("DIVU 9/2 busy-ignore", 6, 32'd4, 34);
    runOp("MUL 3x4 back-to-back", OP_MUL, 32'd3, 32'd4, 32'd12, 2);

    applyStimulus(5'b00000, 32'd3, 32'd4);
    checkOutput("bad op busy", 32'(busy), 32'h0);
    step();
    checkOutput("bad op result", result, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Multi-cycle RV32M execution unit for the EX stage. It serves as the sequential counterpart to the combinational M-extension ALU path.
- Accepts one MUL/DIV-class operation through a start/busy/result_valid handshake and returns the 32-bit result.
- Division uses a 32-iteration restoring algorithm. Multiplication has a fixed 2-cycle latency.
- `busy` drives the hazard unit's EX stall; `flush` aborts on pipeline kill.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified).
- ITER_BITS, 6, width of the division iteration counter (counts 0..32).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request strobe; sampled only when busy=0.
- alu_control  input  5  op select: 01000 MUL, 01001 MULH, 01010 MULHU, 01011 MULHSU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- data1  input  WIDTH  rs1 operand (dividend / multiplicand).
- data2  input  WIDTH  rs2 operand (divisor / multiplier).
- flush  input  1  abort in-flight op.
- busy  output  1  unit holds an op (state != IDLE).
- result_valid  output  1  one-cycle pulse, result is valid.
- result  output  WIDTH  result; held stable until the next accepted op.

Behaviour:
- Reset: state=IDLE, busy=0, result_valid=0, result=0, counter=0, internal registers=0. Reset has priority over flush and start, including mid-operation.
- States:
  - IDLE: accept when start=1 and alu_control is in 01000..01111. Codes outside that range are ignored and the unit stays IDLE.
  - MUL: 1 cycle. Computes the 64-bit product with signedness per op, then goes to DONE.
    - MUL selects bits [31:0].
    - MULH selects [63:32] of signed×signed.
    - MULHU selects [63:32] of unsigned×unsigned.
    - MULHSU selects [63:32] of signed data1 × unsigned data2.
  - DIV: on accept, latch magnitudes |data1| and |data2| for signed ops (raw values for unsigned ops), the quotient sign (s1 XOR s2) and the remainder sign (s1). Each cycle performs one restoring step: shift {rem,quo} left by 1, trial subtract the divisor, set the quotient LSB if the result is non-negative. Exit after 32 iterations to DONE.
  - DONE: apply sign correction (two's-complement negate), register result, pulse result_valid=1 for exactly this cycle, then return to IDLE.
- Special cases are detected at accept and go straight to DONE with no iterations:
  - Divide by zero (data2=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give data1.
  - Signed overflow (DIV/REM, data1=0x80000000, data2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Latency, counted from the start-high cycle (cycle 0) to the result_valid-high cycle:
  - MUL-class ops: 2.
  - Special-case divides: 1.
  - Normal divides: 34 (32 iterations plus 1 cycle in DONE after the latch cycle).
- Handshake rules:
  - busy rises the cycle after accept and falls in the cycle after DONE, so busy=0 in the cycle after the result_valid pulse.
  - A start while busy=1 is ignored and no queueing occurs.
  - start in the same cycle busy falls is accepted normally.
- Operands are latched at accept. Changes on data1/data2/alu_control while busy have no effect.
- Flush:
  - In MUL or DIV: next state is IDLE, no result_valid pulse, result retains its previous value, counter cleared.
  - In DONE: result_valid still pulses, because the result is already committed.
  - In IDLE together with start: flush wins and the op is not accepted.
- Counter wrap: the counter saturates conceptually at 32 and is reset on every accept; it never wraps within an op.

Test Plan:
- Reset mid-divide: start DIVU 100/7, assert reset at cycle 10 → busy=0, result=0, result_valid=0 next cycle; then DIVU 100/7 → result 14 at cycle 34, and REMU 100/7 → 2.
- Signed divide/rem: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD (-3); REM 0xFFFFFFF9/2 → 0xFFFFFFFF (-1); each takes 34 cycles with busy high from cycle 1 through cycle 34.
- Multiply variants, each at cycle 2:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 7×6 → 42.
- Corner divides, each with result_valid at cycle 1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush mid-op: start DIV 1000/3, flush at cycle 12 → no result_valid, busy=0 at cycle 13, result unchanged; a start at cycle 13 of REMU 1000/3 → 1.
- Busy-ignore and back-to-back: pulse start with MUL 3×4 while a DIVU 9/2 is in flight → ignored, DIVU returns 4. Then start MUL 3×4 in the first busy=0 cycle → 12 two cycles later. Also start with alu_control=00000 → busy stays 0.
